// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Operand-forwarding and hazard controller that sits beside decode.
// Each D-stage source is compared against the destinations of the NUM_FWD
// youngest in-flight producers. The youngest match gives the X-stage bypass
// select, and that select is registered into X. A load scoreboard tracks
// destinations whose data has not returned yet. A D-stage stall is raised for
// load-use hazards and for WAW hazards on a pending load.
// Loads are never bypassed. A consumer of a load waits until the response
// edge has written the regfile, then reads the regfile (select 0).

module hazard_forward_unit #(
  parameter  int NUM_FWD = 2,
  parameter  int ADDR_W  = 5,
  parameter  int CNT_W   = 16,
  localparam int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      d_valid,
  input  logic [ADDR_W-1:0]         d_rs1,
  input  logic [ADDR_W-1:0]         d_rs2,
  input  logic                      d_rs1_used,
  input  logic                      d_rs2_used,
  input  logic [ADDR_W-1:0]         d_rd,
  input  logic                      d_we,
  input  logic [NUM_FWD-1:0]        p_valid,
  input  logic [NUM_FWD-1:0]        p_we,
  input  logic [NUM_FWD-1:0]        p_is_load,
  input  logic [NUM_FWD*ADDR_W-1:0] p_rd,
  input  logic                      ld_resp_valid,
  input  logic [ADDR_W-1:0]         ld_resp_rd,
  output logic                      stall_d,
  output logic [SEL_W-1:0]          fwd_sel_a,
  output logic [SEL_W-1:0]          fwd_sel_b,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic                      sb_err
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0]    r_pending;
  logic [SEL_W-1:0]   r_sel_a;
  logic [SEL_W-1:0]   r_sel_b;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic               r_sb_err;

  logic [NUM_FWD-1:0] w_prod_vld;
  logic               w_use_a;
  logic               w_use_b;
  logic [SEL_W-1:0]   w_sel_a;
  logic [SEL_W-1:0]   w_sel_b;
  logic               w_ld_a;
  logic               w_ld_b;
  logic               w_raw_pend;
  logic               w_waw;
  logic               w_stall;
  logic               w_advance;
  logic               w_ld_set;
  logic [ADDR_W-1:0]  w_ld_set_rd;
  logic [NREG-1:0]    w_pending_nxt;

  // A slot only counts as a producer if it writes a register other than x0
  always_comb begin
    w_prod_vld = '0;
    for (int i = 0; i < NUM_FWD; i++) begin
      w_prod_vld[i] = p_valid[i] & p_we[i] & (p_rd[i*ADDR_W +: ADDR_W] != '0);
    end
  end

  assign w_use_a = d_rs1_used && (d_rs1 != '0);
  assign w_use_b = d_rs2_used && (d_rs2 != '0);

  // Scan oldest to youngest so the youngest (lowest-index) match wins
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_ld_a  = 1'b0;
    w_ld_b  = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (w_use_a && w_prod_vld[i] && (p_rd[i*ADDR_W +: ADDR_W] == d_rs1)) begin
        w_sel_a = SEL_W'(i + 1);
        w_ld_a  = p_is_load[i];
      end
      if (w_use_b && w_prod_vld[i] && (p_rd[i*ADDR_W +: ADDR_W] == d_rs2)) begin
        w_sel_b = SEL_W'(i + 1);
        w_ld_b  = p_is_load[i];
      end
    end
  end

  // A load still in flight blocks readers (RAW) and writers (WAW) of its rd
  assign w_raw_pend = (w_use_a && r_pending[d_rs1]) || (w_use_b && r_pending[d_rs2]);
  assign w_waw      = d_we && (d_rd != '0) && r_pending[d_rd];
  assign w_stall    = d_valid && (w_raw_pend || w_ld_a || w_ld_b || w_waw);
  assign w_advance  = d_valid && !w_stall;

  assign w_ld_set    = w_prod_vld[0] & p_is_load[0];
  assign w_ld_set_rd = p_rd[ADDR_W-1:0];

  // Scoreboard next state: clear on response first, so a same-index set wins
  always_comb begin
    w_pending_nxt = r_pending;
    if (ld_resp_valid) begin
      w_pending_nxt[ld_resp_rd] = 1'b0;
    end
    if (w_ld_set) begin
      w_pending_nxt[w_ld_set_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Bypass selects into X. A bubble reads the regfile
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_a <= '0;
      r_sel_b <= '0;
    end else if (w_advance) begin
      r_sel_a <= w_sel_a;
      r_sel_b <= w_sel_b;
    end else begin
      r_sel_a <= '0;
      r_sel_b <= '0;
    end
  end

  // Saturating count of stalled D cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Sticky flag for a load response that matches no pending entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sb_err <= 1'b0;
    end else if (ld_resp_valid && !r_pending[ld_resp_rd]) begin
      r_sb_err <= 1'b1;
    end
  end

  assign stall_d      = w_stall;
  assign fwd_sel_a    = r_sel_a;
  assign fwd_sel_b    = r_sel_b;
  assign stall_cycles = r_stall_cnt;
  assign sb_err       = r_sb_err;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: a reference model checked on every cycle,
// plus directed vectors with literal expectations. A second instance with a
// 3-bit counter covers saturation.

module tb_hazard_forward_unit;

  localparam int NF = 2;
  localparam int AW = 5;

  logic              clk;
  logic              reset;
  logic              d_valid;
  logic [AW-1:0]     d_rs1, d_rs2, d_rd;
  logic              d_rs1_used, d_rs2_used, d_we;
  logic [NF-1:0]     p_valid, p_we, p_is_load;
  logic [NF*AW-1:0]  p_rd;
  logic              ld_resp_valid;
  logic [AW-1:0]     ld_resp_rd;

  logic              stall_d, stall_d_s;
  logic [1:0]        fwd_sel_a, fwd_sel_b, fwd_sel_a_s, fwd_sel_b_s;
  logic [15:0]       stall_cycles;
  logic [2:0]        stall_cycles_s;
  logic              sb_err, sb_err_s;

  int n_checks = 0;
  int n_err    = 0;

  hazard_forward_unit #(.NUM_FWD(NF), .ADDR_W(AW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_we(d_we),
    .p_valid(p_valid), .p_we(p_we), .p_is_load(p_is_load), .p_rd(p_rd),
    .ld_resp_valid(ld_resp_valid), .ld_resp_rd(ld_resp_rd),
    .stall_d(stall_d), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_cycles(stall_cycles), .sb_err(sb_err)
  );

  hazard_forward_unit #(.NUM_FWD(NF), .ADDR_W(AW), .CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_we(d_we),
    .p_valid(p_valid), .p_we(p_we), .p_is_load(p_is_load), .p_rd(p_rd),
    .ld_resp_valid(ld_resp_valid), .ld_resp_rd(ld_resp_rd),
    .stall_d(stall_d_s), .fwd_sel_a(fwd_sel_a_s), .fwd_sel_b(fwd_sel_b_s),
    .stall_cycles(stall_cycles_s), .sb_err(sb_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_live = 0;
  bit m_pend [32];
  int m_sel_a, m_sel_b, m_cnt16, m_cnt3;
  bit m_err;

  function automatic int slot_rd(input int s);
    logic [NF*AW-1:0] v;
    v = p_rd;
    return int'(v[s*AW +: AW]);
  endfunction

  // Youngest producer writing rs: collect all hits, the first one listed wins
  function automatic void m_pick(input int rs, input bit used, output int sel, output bit is_ld);
    int hits[$];
    sel   = 0;
    is_ld = 0;
    if (!used || rs == 0) return;
    for (int i = 0; i < NF; i++)
      if (p_valid[i] && p_we[i] && slot_rd(i) != 0 && slot_rd(i) == rs) hits.push_back(i);
    if (hits.size() > 0) begin
      sel   = hits[0] + 1;
      is_ld = p_is_load[hits[0]];
    end
  endfunction

  function automatic bit m_stall();
    int sa, sb;
    bit la, lb, hz;
    m_pick(int'(d_rs1), d_rs1_used, sa, la);
    m_pick(int'(d_rs2), d_rs2_used, sb, lb);
    hz = la || lb;
    if (d_rs1_used && d_rs1 != 0 && m_pend[d_rs1]) hz = 1;
    if (d_rs2_used && d_rs2 != 0 && m_pend[d_rs2]) hz = 1;
    if (d_we && d_rd != 0 && m_pend[d_rd]) hz = 1;
    return d_valid && hz;
  endfunction

  always @(posedge clk) begin
    int sa, sb;
    bit la, lb, st;
    if (reset) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_sel_a = 0; m_sel_b = 0; m_cnt16 = 0; m_cnt3 = 0; m_err = 0;
      m_live = 1;
    end else begin
      st = m_stall();
      m_pick(int'(d_rs1), d_rs1_used, sa, la);
      m_pick(int'(d_rs2), d_rs2_used, sb, lb);
      m_sel_a = (d_valid && !st) ? sa : 0;
      m_sel_b = (d_valid && !st) ? sb : 0;
      if (st) begin
        m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
        m_cnt3  = (m_cnt3 == 7) ? 7 : m_cnt3 + 1;
      end
      if (ld_resp_valid && !m_pend[ld_resp_rd]) m_err = 1;
      if (ld_resp_valid) m_pend[ld_resp_rd] = 0;
      if (p_valid[0] && p_we[0] && p_is_load[0] && slot_rd(0) != 0) m_pend[slot_rd(0)] = 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      check("model stall_d", int'(stall_d), int'(m_stall()));
      check("model fwd_sel_a", int'(fwd_sel_a), m_sel_a);
      check("model fwd_sel_b", int'(fwd_sel_b), m_sel_b);
      check("model stall_cycles", int'(stall_cycles), m_cnt16);
      check("model stall_cycles_w3", int'(stall_cycles_s), m_cnt3);
      check("model sb_err", int'(sb_err), int'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_rs1_used = 0; d_rs2_used = 0;
    d_rd = 0; d_we = 0;
    p_valid = 0; p_we = 0; p_is_load = 0; p_rd = 0;
    ld_resp_valid = 0; ld_resp_rd = 0;
  endtask

  task automatic set_p(input int s, input bit ld, input int rd);
    p_valid[s]        = 1'b1;
    p_we[s]           = 1'b1;
    p_is_load[s]      = ld;
    p_rd[s*AW +: AW]  = AW'(rd);
  endtask

  task automatic set_d(input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit we);
    d_valid = 1; d_rs1 = AW'(rs1); d_rs1_used = u1; d_rs2 = AW'(rs2);
    d_rs2_used = u2; d_rd = AW'(rd); d_we = we;
  endtask

  task automatic resp(input int rd);
    ld_resp_valid = 1; ld_resp_rd = AW'(rd);
  endtask

  initial begin
    reset = 1; idle();
    nxt(); nxt();
    reset = 0;
    mid();
    check("reset fwd_sel_a", int'(fwd_sel_a), 0);
    check("reset fwd_sel_b", int'(fwd_sel_b), 0);
    check("reset stall_cycles", int'(stall_cycles), 0);
    check("reset sb_err", int'(sb_err), 0);
    check("reset stall_d", int'(stall_d), 0);
    nxt();

    // back-to-back ALU
    idle(); set_p(0, 0, 5); set_d(5, 1, 3, 1, 0, 0); mid();
    check("alu stall_d", int'(stall_d), 0); nxt();
    idle(); mid();
    check("alu fwd_sel_a", int'(fwd_sel_a), 1);
    check("alu fwd_sel_b", int'(fwd_sel_b), 0); nxt();

    // distance and priority
    idle(); set_p(1, 0, 5); set_d(5, 1, 0, 0, 0, 0); nxt();
    idle(); mid(); check("slot1 fwd_sel_a", int'(fwd_sel_a), 2); nxt();
    idle(); set_p(0, 0, 5); set_p(1, 0, 5); set_d(5, 1, 0, 0, 0, 0); nxt();
    idle(); mid(); check("youngest fwd_sel_a", int'(fwd_sel_a), 1); nxt();
    idle(); set_p(0, 0, 5); set_p(1, 0, 9); set_d(5, 1, 9, 1, 0, 0); nxt();
    idle(); mid();
    check("split fwd_sel_a", int'(fwd_sel_a), 1);
    check("split fwd_sel_b", int'(fwd_sel_b), 2); nxt();

    // x0 and unused operand
    idle(); set_p(0, 0, 0); set_d(0, 1, 0, 0, 0, 0); nxt();
    idle(); mid(); check("x0 fwd_sel_a", int'(fwd_sel_a), 0); nxt();
    idle(); set_p(0, 0, 6); set_d(0, 0, 6, 0, 0, 0); mid();
    check("unused stall_d", int'(stall_d), 0); nxt();
    idle(); mid(); check("unused fwd_sel_b", int'(fwd_sel_b), 0); nxt();

    // load-use: load in slot0 at cycle 0, consumer in D from cycle 1
    idle(); set_p(0, 1, 7); mid(); check("ld c0 stall_d", int'(stall_d), 0); nxt();
    idle(); set_p(1, 1, 7); set_d(0, 0, 7, 1, 0, 0); mid();
    check("ld c1 stall_d", int'(stall_d), 1); nxt();
    for (int c = 2; c <= 3; c++) begin
      idle(); set_d(0, 0, 7, 1, 0, 0); mid(); check("ld pend stall_d", int'(stall_d), 1); nxt();
    end
    idle(); set_d(0, 0, 7, 1, 0, 0); resp(7); mid();
    check("ld c4 stall_d", int'(stall_d), 1); nxt();
    idle(); set_d(0, 0, 7, 1, 0, 0); mid();
    check("ld c5 stall_d", int'(stall_d), 0);
    check("ld c5 stall_cycles", int'(stall_cycles), 4); nxt();
    idle(); mid();
    check("ld c6 fwd_sel_b", int'(fwd_sel_b), 0);
    check("ld c6 sb_err", int'(sb_err), 0); nxt();

    // slot0 load use and WAW on pending load
    idle(); set_p(0, 1, 7); set_d(7, 1, 0, 0, 0, 0); mid();
    check("slot0 load stall_d", int'(stall_d), 1); nxt();
    idle(); set_d(0, 0, 0, 0, 7, 1); mid(); check("waw stall_d", int'(stall_d), 1); nxt();
    idle(); set_d(0, 0, 0, 0, 7, 1); resp(7); mid();
    check("waw resp stall_d", int'(stall_d), 1); nxt();
    idle(); set_d(0, 0, 0, 0, 7, 1); mid();
    check("waw clear stall_d", int'(stall_d), 0);
    check("waw stall_cycles", int'(stall_cycles), 7);
    check("w3 stall_cycles 7", int'(stall_cycles_s), 7); nxt();

    // saturation: six more stalls on pending x8
    idle(); set_p(0, 1, 8); nxt();
    for (int c = 0; c < 6; c++) begin
      idle(); set_d(8, 1, 0, 0, 0, 0); nxt();
    end
    idle(); mid();
    check("sat stall_cycles", int'(stall_cycles), 13);
    check("sat stall_cycles_w3", int'(stall_cycles_s), 7); nxt();

    // unexpected response sets sticky error
    idle(); resp(12); mid(); check("err before", int'(sb_err), 0); nxt();
    idle(); mid(); check("err set", int'(sb_err), 1); nxt();
    idle(); nxt(); mid(); check("err sticky", int'(sb_err), 1); nxt();
    idle(); resp(8); nxt();
    idle(); set_d(8, 1, 0, 0, 0, 0); mid(); check("x8 freed stall_d", int'(stall_d), 0); nxt();

    // reset in the middle of a stall
    idle(); set_p(0, 1, 7); nxt();
    idle(); set_d(7, 1, 0, 0, 0, 0); mid(); check("pre-reset stall_d", int'(stall_d), 1); nxt();
    idle(); set_d(7, 1, 0, 0, 0, 0); reset = 1; mid(); nxt();
    reset = 0; idle(); set_d(7, 1, 0, 0, 0, 0); mid();
    check("post-reset stall_d", int'(stall_d), 0);
    check("post-reset stall_cycles", int'(stall_cycles), 0);
    check("post-reset sb_err", int'(sb_err), 0);
    check("post-reset fwd_sel_a", int'(fwd_sel_a), 0); nxt();
    idle(); resp(7); nxt();
    idle(); mid(); check("stale resp sb_err", int'(sb_err), 1); nxt();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
